// File: rtl/clk_step_ctrl.sv
// Debug sequencer for the stepped-clock gate: run/halt/step-N commands over a
// small register port, registered clock-enable, cycle total and breakpoint.
module clk_step_ctrl #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  input  logic              ext_halt_i,
  output logic              clk_en_o,
  output logic              halted_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_STEP   = 2'd1,
    S_RUN    = 2'd2
  } state_e;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STEPN  = 3'd1;
  localparam logic [2:0] A_STATUS = 3'd2;
  localparam logic [2:0] A_CYCLES = 3'd3;
  localparam logic [2:0] A_BREAK  = 3'd4;

  state_e           state;
  logic [CNT_W-1:0] step_n, cycles, brk, remaining;
  logic             brk_en, done_sticky;

  logic [2:0]       reg_sel;
  logic             wr, rd, wr_ctrl;
  logic             cmd_run, cmd_halt, cmd_step, halt_req;
  logic             wr_cycles, wr_status_clr;
  logic             enabled, brk_hit, last_step, done_evt, start_ok;
  logic [CNT_W-1:0] cyc_inc;
  logic [31:0]      rd_val;
  logic             unused_bits;

  assign reg_sel       = addr_i[4:2];
  assign wr            = req_i & we_i;
  assign rd            = req_i & ~we_i;
  assign wr_ctrl       = wr && (reg_sel == A_CTRL);
  assign cmd_run       = wr_ctrl & wdata_i[0];
  assign cmd_halt      = wr_ctrl & wdata_i[1];
  assign cmd_step      = wr_ctrl & wdata_i[2];
  assign halt_req      = cmd_halt | ext_halt_i;
  assign wr_cycles     = wr && (reg_sel == A_CYCLES);
  assign wr_status_clr = wr && (reg_sel == A_STATUS) && wdata_i[1];
  assign unused_bits   = ^{addr_i, wdata_i};

  assign enabled   = (state == S_STEP) || (state == S_RUN);
  assign cyc_inc   = cycles + CNT_W'(1);
  assign brk_hit   = enabled & brk_en & (cyc_inc == brk);
  assign last_step = (state == S_STEP) && (remaining == CNT_W'(1));
  // A halt request (bus or external) blocks any start from HALTED.
  assign start_ok  = (state == S_HALTED) & ~halt_req;
  // Halt beats completion: an aborted step or run never reports done.
  assign done_evt  = (start_ok & cmd_step & (step_n == '0)) |
                     (enabled & ~halt_req & (brk_hit | last_step));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_HALTED;
      clk_en_o    <= 1'b0;
      halted_o    <= 1'b1;
      done_o      <= 1'b0;
      remaining   <= '0;
      cycles      <= '0;
      done_sticky <= 1'b0;
    end else begin
      done_o <= done_evt;
      if (done_evt)           done_sticky <= 1'b1;
      else if (wr_status_clr) done_sticky <= 1'b0;

      if (wr_cycles)    cycles <= wdata_i[CNT_W-1:0];
      else if (enabled) cycles <= cyc_inc;

      case (state)
        S_HALTED: begin
          if (start_ok && cmd_step && (step_n != '0)) begin
            state     <= S_STEP;
            remaining <= step_n;
            clk_en_o  <= 1'b1;
            halted_o  <= 1'b0;
          end else if (start_ok && cmd_run && !cmd_step) begin
            state    <= S_RUN;
            clk_en_o <= 1'b1;
            halted_o <= 1'b0;
          end
        end
        S_STEP, S_RUN: begin
          if (halt_req || brk_hit || last_step) begin
            state     <= S_HALTED;
            remaining <= '0;
            clk_en_o  <= 1'b0;
            halted_o  <= 1'b1;
          end else if (state == S_STEP) begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: begin
          state     <= S_HALTED;
          remaining <= '0;
          clk_en_o  <= 1'b0;
          halted_o  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_n <= '0;
      brk    <= '0;
      brk_en <= 1'b0;
    end else if (wr) begin
      case (reg_sel)
        A_CTRL:  brk_en <= wdata_i[3];
        A_STEPN: step_n <= wdata_i[CNT_W-1:0];
        A_BREAK: brk    <= wdata_i[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      A_CTRL:   rd_val = {28'd0, brk_en, 3'b000};
      A_STEPN:  rd_val = 32'(step_n);
      A_STATUS: rd_val = {28'd0, state, done_sticky, halted_o};
      A_CYCLES: rd_val = 32'(cycles);
      A_BREAK:  rd_val = 32'(brk);
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= rd;
      rdata_o  <= rd ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl: register table plus step/run/halt sequences.
module tb_clk_step_ctrl;

  logic        clk, rst_n;
  logic        req, we, ext_halt;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        rvalid, clk_en, halted, done;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;

  clk_step_ctrl #(.CNT_W(32), .ADDR_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .ext_halt_i(ext_halt),
    .clk_en_o(clk_en), .halted_o(halted), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] CTRL = 5'h00, STEPN = 5'h04, STATUS = 5'h08,
                         CYCLES = 5'h0C, BREAK = 5'h10;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[19];
  localparam int N_RST = 6;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    chk("rvalid", {31'd0, rvalid}, 32'd1);
    d = rdata;
  endtask

  task automatic watch(input int n, output int en_cnt, output int done_cnt);
    en_cnt = 0; done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (clk_en) en_cnt++;
      if (done) done_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int i);
    logic [31:0] d;
    if (tbl[i].we) bus_wr(tbl[i].addr, tbl[i].wdata);
    else begin
      bus_rd(tbl[i].addr, d);
      chk($sformatf("vec%0d addr 0x%02h", i, tbl[i].addr), d, tbl[i].exp);
    end
  endtask

  initial begin
    logic [31:0] d;
    int en_c, dn_c;

    tbl[0]  = '{1'b0, CTRL,   32'h0,         32'h0};
    tbl[1]  = '{1'b0, STEPN,  32'h0,         32'h0};
    tbl[2]  = '{1'b0, STATUS, 32'h0,         32'h1};
    tbl[3]  = '{1'b0, CYCLES, 32'h0,         32'h0};
    tbl[4]  = '{1'b0, BREAK,  32'h0,         32'h0};
    tbl[5]  = '{1'b0, 5'h14,  32'h0,         32'h0};
    tbl[6]  = '{1'b1, STEPN,  32'hA5A5_1234, 32'h0};
    tbl[7]  = '{1'b0, STEPN,  32'h0,         32'hA5A5_1234};
    tbl[8]  = '{1'b1, BREAK,  32'hDEAD_BEEF, 32'h0};
    tbl[9]  = '{1'b0, BREAK,  32'h0,         32'hDEAD_BEEF};
    tbl[10] = '{1'b1, CTRL,   32'h8,         32'h0};
    tbl[11] = '{1'b0, CTRL,   32'h0,         32'h8};
    tbl[12] = '{1'b1, 5'h18,  32'hFFFF_FFFF, 32'h0};
    tbl[13] = '{1'b0, 5'h18,  32'h0,         32'h0};
    tbl[14] = '{1'b1, CYCLES, 32'h1234,      32'h0};
    tbl[15] = '{1'b0, CYCLES, 32'h0,         32'h1234};
    tbl[16] = '{1'b1, CTRL,   32'h0,         32'h0};
    tbl[17] = '{1'b0, CTRL,   32'h0,         32'h0};
    tbl[18] = '{1'b0, STATUS, 32'h0,         32'h1};

    req = 0; we = 0; addr = '0; wdata = '0; ext_halt = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst clk_en", {31'd0, clk_en}, 32'd0);
    chk("rst halted", {31'd0, halted}, 32'd1);
    chk("rst done",   {31'd0, done},   32'd0);
    chk("rst rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst rdata",  rdata,           32'd0);

    for (int i = 0; i < 19; i++) run_vec(i);
    @(negedge clk);
    chk("rvalid one cycle", {31'd0, rvalid}, 32'd0);

    // Step 5: enable high five cycles, one done, status halted+done.
    bus_wr(CYCLES, 32'd0);
    bus_wr(STEPN, 32'd5);
    bus_wr(CTRL, 32'h4);
    watch(10, en_c, dn_c);
    chk("step5 en cycles", en_c, 5);
    chk("step5 done cnt", dn_c, 1);
    bus_rd(CYCLES, d); chk("step5 CYCLES", d, 32'd5);
    bus_rd(STATUS, d); chk("step5 STATUS", d, 32'h3);
    bus_wr(STATUS, 32'h2);
    bus_rd(STATUS, d); chk("done W1C", d, 32'h1);

    // Run 20 idle cycles then halt.
    bus_wr(CYCLES, 32'd0);
    bus_wr(CTRL, 32'h1);
    chk("run clk_en", {31'd0, clk_en}, 32'd1);
    repeat (20) @(negedge clk);
    bus_wr(CTRL, 32'h2);
    chk("halt clk_en", {31'd0, clk_en}, 32'd0);
    chk("halt no done", {31'd0, done}, 32'd0);
    bus_rd(CYCLES, d); chk("run CYCLES", d, 32'd21);
    bus_rd(STATUS, d); chk("halt STATUS", d, 32'h1);

    // Breakpoint at 10 while running.
    bus_wr(CYCLES, 32'd0);
    bus_wr(BREAK, 32'd10);
    bus_wr(CTRL, 32'h9);
    watch(15, en_c, dn_c);
    chk("brk en cycles", en_c, 10);
    chk("brk done cnt", dn_c, 1);
    chk("brk halted", {31'd0, halted}, 32'd1);
    bus_rd(CYCLES, d); chk("brk CYCLES", d, 32'd10);
    bus_rd(CTRL, d);   chk("brk CTRL", d, 32'h8);
    bus_wr(CTRL, 32'h0);
    bus_wr(STATUS, 32'h2);

    // External halt after three enabled edges; the fourth edge still counts.
    bus_wr(CYCLES, 32'd0);
    bus_wr(STEPN, 32'd100);
    bus_wr(CTRL, 32'h4);
    repeat (3) @(negedge clk);
    ext_halt = 1'b1;
    @(negedge clk);
    chk("ext clk_en", {31'd0, clk_en}, 32'd0);
    chk("ext done", {31'd0, done}, 32'd0);
    bus_wr(CTRL, 32'h4);
    chk("ext blocks step", {31'd0, clk_en}, 32'd0);
    bus_rd(CYCLES, d); chk("ext CYCLES", d, 32'd4);
    bus_rd(STATUS, d); chk("ext STATUS", d, 32'h1);
    ext_halt = 1'b0;

    // STEP_N = 0: done pulse only.
    bus_wr(STEPN, 32'd0);
    bus_wr(CTRL, 32'h4);
    chk("step0 done", {31'd0, done}, 32'd1);
    chk("step0 clk_en", {31'd0, clk_en}, 32'd0);
    @(negedge clk);
    chk("step0 pulse len", {31'd0, done}, 32'd0);

    // STEP + RUN together: step wins.
    bus_wr(STEPN, 32'd2);
    bus_wr(CTRL, 32'h5);
    watch(6, en_c, dn_c);
    chk("step+run en", en_c, 2);
    chk("step+run done", dn_c, 1);

    // STEP_N rewrite mid-step leaves the step length unchanged.
    bus_wr(STEPN, 32'd3);
    bus_wr(CTRL, 32'h4);
    bus_wr(STEPN, 32'd50);
    watch(6, en_c, dn_c);
    chk("stepn rewrite en", en_c, 2);
    chk("stepn rewrite done", dn_c, 1);

    // Wrap of CYCLES.
    bus_wr(CYCLES, 32'hFFFF_FFFE);
    bus_wr(STEPN, 32'd4);
    bus_wr(CTRL, 32'h4);
    watch(8, en_c, dn_c);
    chk("wrap en", en_c, 4);
    bus_rd(CYCLES, d); chk("wrap CYCLES", d, 32'd2);

    // Reset mid-run: enable drops immediately, registers back to zero.
    bus_wr(BREAK, 32'h55);
    bus_wr(CTRL, 32'h1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async rst clk_en", {31'd0, clk_en}, 32'd0);
    chk("async rst halted", {31'd0, halted}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N_RST; i++) run_vec(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
